spi_read_seq: RTL and testbench

- Hardware sequencer and bus arbiter in front of the spi peripheral's register port.
- Executes complete SPI-flash read transactions autonomously: command byte, 24-bit address, then N data bytes streamed out with a valid/ready handshake.
- The CPU register port passes through to the spi block when the sequencer does not own it.
- Sits between the CPU peripheral decode and the spi block; used for boot/code fetch from flash.

---
 rtl/spi_read_seq.sv | 198 +++++++++++++++++++
 tb/tb_spi_read_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_read_seq.sv
// spi_read_seq: autonomous SPI-flash read sequencer and register-port arbiter
// placed in front of the spi peripheral.
//
// When idle, the CPU register port passes straight through to the spi block.
// On an accepted request the sequencer takes the port and performs:
//   command byte (addr 0 write), 3 address bytes (addr 1 writes), then per data
//   byte a dummy addr-1 write, a wait for spi_irq, and a read (addr 1, or addr 0
//   on the last byte to release CS). Bytes leave on out_valid/out_ready.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req/req_addr/req_len/ack      transaction request (req_len 0 = 2**LEN_W)
//   busy, done                    sequencer owns spi port / transaction finished
//   out_valid/out_data/out_ready  data byte stream
//   cpu_*                         CPU register port (cpu_stall = retry)
//   spi_*                         spi block register port and byte-done irq
module spi_read_seq #(
  parameter int unsigned SEL   = 0,
  parameter logic [7:0]  CMD   = 8'h03,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  input  logic [2:0]       cpu_addr,
  input  logic [7:0]       cpu_wdata,
  input  logic [1:0]       cpu_sel,
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_stall,
  output logic [2:0]       spi_addr,
  output logic [7:0]       spi_wdata,
  output logic [1:0]       spi_sel,
  output logic             spi_read,
  output logic             spi_write,
  input  logic [7:0]       spi_rdata,
  input  logic             spi_irq
);

  localparam logic [1:0]   SEL_L   = SEL[1:0];
  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_WAIT, S_DSTART, S_FETCH, S_HOLD
  } state_e;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             cpu_open_q, cpu_open_d;

  logic             seq_write, seq_read;
  logic [2:0]       seq_addr;
  logic [7:0]       seq_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cpu_open_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cpu_open_q  <= cpu_open_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cpu_rdata = spi_rdata;

  // Sequencer FSM
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    addr_d      = addr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack         = 1'b0;
    done        = 1'b0;
    seq_write   = 1'b0;
    seq_read    = 1'b0;
    seq_addr    = 3'd1;
    seq_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        // A CPU access in the same cycle, or an open CPU transaction, wins.
        if (req && !cpu_open_q && !cpu_read && !cpu_write) begin
          ack     = 1'b1;
          addr_d  = req_addr;
          count_d = (req_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        seq_write = 1'b1;
        seq_addr  = 3'd0;
        seq_wdata = CMD;
        ret_d     = S_A2;
        state_d   = S_WAIT;
      end
      S_A2: begin
        seq_write = 1'b1;
        seq_wdata = addr_q[23:16];
        ret_d     = S_A1;
        state_d   = S_WAIT;
      end
      S_A1: begin
        seq_write = 1'b1;
        seq_wdata = addr_q[15:8];
        ret_d     = S_A0;
        state_d   = S_WAIT;
      end
      S_A0: begin
        seq_write = 1'b1;
        seq_wdata = addr_q[7:0];
        ret_d     = S_DSTART;
        state_d   = S_WAIT;
      end
      S_DSTART: begin
        seq_write = 1'b1;
        seq_wdata = 8'h00;
        ret_d     = S_FETCH;
        state_d   = S_WAIT;
      end
      // spi_irq was cleared by the write one cycle earlier, so it is never stale here.
      S_WAIT: begin
        if (spi_irq) state_d = ret_q;
      end
      S_FETCH: begin
        seq_read    = 1'b1;
        seq_addr    = (count_q == CNT_ONE) ? 3'd0 : 3'd1;
        out_data_d  = spi_rdata;
        count_d     = count_q - CNT_ONE;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count_q == '0) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DSTART;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port mux and CPU open-transaction tracking
  always_comb begin
    cpu_open_d = cpu_open_q;
    if (busy) begin
      spi_addr  = seq_addr;
      spi_wdata = seq_wdata;
      spi_sel   = SEL_L;
      spi_read  = seq_read;
      spi_write = seq_write;
      cpu_stall = cpu_read | cpu_write;
    end else begin
      spi_addr  = cpu_addr;
      spi_wdata = cpu_wdata;
      spi_sel   = cpu_sel;
      spi_read  = cpu_read;
      spi_write = cpu_write;
      cpu_stall = 1'b0;
      if (cpu_write && cpu_addr == 3'd0)     cpu_open_d = 1'b1;
      else if (cpu_read && cpu_addr == 3'd0) cpu_open_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_read_seq.sv
module tb_spi_read_seq;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned SHIFT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             ack, busy, done, out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic [2:0]       cpu_addr;
  logic [7:0]       cpu_wdata;
  logic [1:0]       cpu_sel;
  logic             cpu_read, cpu_write;
  logic [7:0]       cpu_rdata;
  logic             cpu_stall;
  logic [2:0]       spi_addr;
  logic [7:0]       spi_wdata;
  logic [1:0]       spi_sel;
  logic             spi_read, spi_write;
  logic [7:0]       spi_rdata;
  logic             spi_irq;

  int errors = 0;
  int checks = 0;

  spi_read_seq #(.SEL(1), .CMD(8'h03), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_addr(req_addr), .req_len(req_len),
    .ack(ack), .busy(busy), .done(done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_sel(spi_sel),
    .spi_read(spi_read), .spi_write(spi_write),
    .spi_rdata(spi_rdata), .spi_irq(spi_irq)
  );

  always #5 clk = ~clk;

  // ---------------- spi block + flash model ----------------
  function automatic logic [7:0] flash(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  logic [2:0]  wa_q[$];
  logic [7:0]  wd_q[$];
  logic [1:0]  ws_q[$];
  logic [2:0]  ra_q[$];
  logic        cs_n;
  logic        irq_m;
  logic [7:0]  rx;
  int unsigned shift_cnt;
  int unsigned idx;
  logic [23:0] fa;
  int          cs_rise;

  assign spi_rdata = rx;
  assign spi_irq   = irq_m;

  always @(posedge clk) begin
    if (reset) begin
      cs_n      <= 1'b1;
      irq_m     <= 1'b0;
      rx        <= 8'hFF;
      shift_cnt <= 0;
      idx       <= 0;
      fa        <= '0;
    end else begin
      if (spi_write) begin
        wa_q.push_back(spi_addr);
        wd_q.push_back(spi_wdata);
        ws_q.push_back(spi_sel);
        shift_cnt <= SHIFT;
        irq_m     <= 1'b0;
        if (spi_addr == 3'd0) begin
          cs_n <= 1'b0;
          idx  <= 0;
        end else begin
          idx <= idx + 1;
          if (idx < 3) fa <= {fa[15:0], spi_wdata};
        end
      end else if (shift_cnt != 0) begin
        shift_cnt <= shift_cnt - 1;
        if (shift_cnt == 1) begin
          irq_m <= 1'b1;
          rx    <= (idx >= 4) ? flash(fa + 24'(idx - 4)) : 8'hFF;
        end
      end
      if (spi_read) begin
        ra_q.push_back(spi_addr);
        if (spi_addr == 3'd0) begin
          cs_n <= 1'b1;
          if (!cs_n) cs_rise <= cs_rise + 1;
        end
      end
    end
  end

  int ack_busy_n = 0;
  always @(negedge clk) if (ack && busy) ack_busy_n <= ack_busy_n + 1;

  logic [7:0] out_q[$];

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ws_q.delete(); ra_q.delete(); out_q.delete();
  endtask

  // waited = cycles until ack, or -1 if none within max_cyc
  task automatic issue_req(input logic [23:0] a, input logic [LEN_W-1:0] l,
                           input int max_cyc, output int waited);
    req = 1'b1; req_addr = a; req_len = l; waited = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (ack) begin
        waited = c;
        tick();
        break;
      end
      tick();
    end
    req = 1'b0;
  endtask

  // Collect handshaked bytes until done; ndone = -1 on timeout.
  task automatic collect(input int max_cyc, output int ndone);
    ndone = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (done) ndone = out_q.size();
      tick();
      if (ndone >= 0) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cs_rise = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ack !== 1'b0)       begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got=%b want=0", cpu_stall); end
    checks++; if (spi_write !== 1'b0 || spi_read !== 1'b0)
      begin errors++; $display("FAIL reset_spi_strobes got=%b%b want=00", spi_write, spi_read); end
    tick();
  endtask

  task automatic test_basic_read();
    logic [2:0] exp_a [6];
    logic [7:0] exp_d [6];
    int waited, nd, bad, rise0;
    exp_a = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    exp_d = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    clear_logs();
    rise0 = cs_rise;
    out_ready = 1'b1;
    issue_req(24'h123456, 8'd2, 10, waited);
    checks++; if (waited !== 0) begin errors++; $display("FAIL basic_ack_latency got=%0d want=0", waited); end
    collect(500, nd);
    checks++; if (nd !== 2) begin errors++; $display("FAIL basic_done got=%0d want=2 bytes at done", nd); end
    checks++; if (wa_q.size() !== 6) begin errors++; $display("FAIL basic_write_count got=%0d want=6", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < 6 && i < wa_q.size(); i++)
      if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i] || ws_q[i] !== 2'd1) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_write_seq got=%0d bad want=0", bad); end
    checks++; if (ra_q.size() !== 2 || ra_q[0] !== 3'd1 || ra_q[$] !== 3'd0)
      begin errors++; $display("FAIL basic_reads got=%0d reads want=2 (addr 1 then 0)", ra_q.size()); end
    checks++; if (out_q.size() !== 2 || out_q[0] !== 8'hC7 || out_q[$] !== 8'hC6)
      begin errors++; $display("FAIL basic_data got=%0d bytes want=C7,C6", out_q.size()); end
    checks++; if (cs_n !== 1'b1 || cs_rise - rise0 !== 1)
      begin errors++; $display("FAIL basic_cs got=cs_n %b rises %0d want=1 1", cs_n, cs_rise - rise0); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_single_done got=%0d extra want=0", bad); end
  endtask

  task automatic test_cpu_stall();
    int waited, bad, ok;
    clear_logs();
    issue_req(24'hABCDEF, 8'd1, 10, waited);
    cpu_write = 1'b1; cpu_addr = 3'd1; cpu_wdata = 8'h77; cpu_sel = 2'd0;
    bad = 0; ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (busy && !cpu_stall) bad++;
      if (spi_write && spi_wdata == 8'h77) bad++;
      if (done) begin ok = 1; tick(); break; end
      tick();
    end
    checks++; if (ok !== 1 || bad !== 0) begin errors++; $display("FAIL stall_during_busy got=done %0d bad %0d want=1 0", ok, bad); end
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || spi_write !== 1'b1 || spi_wdata !== 8'h77 || spi_addr !== 3'd1)
      begin errors++; $display("FAIL stall_retry_pass got=stall %b wr %b data %h want=0 1 77", cpu_stall, spi_write, spi_wdata); end
    tick();
    cpu_write = 1'b0; cpu_read = 1'b1;
    @(negedge clk);
    checks++; if (cpu_rdata !== 8'h87) begin errors++; $display("FAIL stall_cpu_rdata got=%h want=87", cpu_rdata); end
    tick();
    cpu_read = 1'b0;
  endtask

  task automatic test_cpu_open();
    int bad, nd;
    clear_logs();
    cpu_write = 1'b1; cpu_addr = 3'd0; cpu_wdata = 8'h9F;
    tick();
    cpu_write = 1'b0;
    req = 1'b1; req_addr = 24'h000300; req_len = 8'd1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack || busy) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL open_blocks_req got=%0d want=0", bad); end
    cpu_read = 1'b1; cpu_addr = 3'd0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL open_same_cycle_ack got=%b want=0", ack); end
    tick();
    cpu_read = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL open_ack_after_close got=%b want=1", ack); end
    tick();
    req = 1'b0;
    collect(500, nd);
    checks++; if (nd !== 1 || out_q.size() !== 1 || out_q[0] !== 8'hA6)
      begin errors++; $display("FAIL open_data got=%0d bytes want=1 byte A6", out_q.size()); end
  endtask

  task automatic test_backpressure();
    int waited, nd, bad, wn, rn, seen;
    logic [7:0] d0;
    clear_logs();
    out_ready = 1'b0;
    issue_req(24'h000040, 8'd2, 10, waited);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL bp_first_valid got=%0d want=1", seen); end
    d0 = out_data; wn = wa_q.size(); rn = ra_q.size();
    tick();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!out_valid || out_data !== d0 || spi_write || spi_read || cs_n !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0 || wa_q.size() !== wn || ra_q.size() !== rn)
      begin errors++; $display("FAIL bp_hold_stable got=%0d bad cycles want=0", bad); end
    out_ready = 1'b1;
    collect(500, nd);
    checks++; if (nd !== 2 || out_q.size() !== 2 || out_q[0] !== 8'hE5 || out_q[$] !== 8'hE4)
      begin errors++; $display("FAIL bp_data got=%0d bytes want=E5,E4", out_q.size()); end
  endtask

  task automatic test_len_zero();
    int waited, nd, bad;
    clear_logs();
    issue_req(24'h000100, 8'd0, 10, waited);
    collect(6000, nd);
    checks++; if (nd !== 256) begin errors++; $display("FAIL len0_done got=%0d bytes at done want=256", nd); end
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== (8'(i) ^ 8'hA4)) bad++;
    checks++; if (bad !== 0 || out_q.size() !== 256)
      begin errors++; $display("FAIL len0_data got=%0d bad of %0d want=0 of 256", bad, out_q.size()); end
  endtask

  task automatic test_reset_mid();
    int waited, nd, seen;
    clear_logs();
    issue_req(24'h0A0B0C, 8'd3, 10, waited);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (wa_q.size() == 3) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_mid_reach_a1 got=%0d writes want=3", wa_q.size()); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || cs_n !== 1'b1)
      begin errors++; $display("FAIL rst_mid_state got=busy %b ov %b cs_n %b want=0 0 1", busy, out_valid, cs_n); end
    reset = 1'b0;
    tick();
    clear_logs();
    issue_req(24'h001020, 8'd1, 10, waited);
    checks++; if (waited !== 0) begin errors++; $display("FAIL rst_mid_new_ack got=%0d want=0", waited); end
    collect(500, nd);
    checks++; if (nd !== 1 || out_q.size() !== 1 || out_q[0] !== 8'h95)
      begin errors++; $display("FAIL rst_mid_new_data got=%0d bytes want=1 byte 95", out_q.size()); end
  endtask

  task automatic test_back_to_back();
    int acks, dones;
    clear_logs();
    acks = 0; dones = 0;
    req = 1'b1; req_addr = 24'h000200; req_len = 8'd1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (ack) acks++;
      if (done) dones++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      tick();
      if (acks >= 2) req = 1'b0;
      if (dones >= 2) break;
    end
    req = 1'b0;
    checks++; if (acks !== 2 || dones !== 2)
      begin errors++; $display("FAIL b2b_counts got=acks %0d dones %0d want=2 2", acks, dones); end
    checks++; if (out_q.size() !== 2 || out_q[0] !== 8'hA7 || out_q[$] !== 8'hA7)
      begin errors++; $display("FAIL b2b_data got=%0d bytes want=A7,A7", out_q.size()); end
    checks++; if (ack_busy_n !== 0) begin errors++; $display("FAIL ack_while_busy got=%0d want=0", ack_busy_n); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_cpu_stall();
    test_cpu_open();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
